sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Upstream stage of the SDRAM controller.
- Arbitrates between the CPU instruction-fetch port and the load/store port, and presents one registered request to the controller's rw_req/rw/size/address/write_data interface.
- Holds the request until the controller's data_valid pulse, then returns the read data and a one-cycle ready to the granted master.
- Requests outside the SDRAM window, or requests that time out, are completed locally with an error flag, so the CPU never hangs.

Parameters:
- SDRAM_BASE, 32'h0001_0000, lowest SDRAM address; the window also requires addr[31]==0.
- TIMEOUT, 1024, cycles to wait for mem_data_valid before aborting; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- i_req  in  1  fetch request, level; held until i_ready
- i_addr  in  32  fetch address; always a word read
- i_rdata  out  32  fetch data; valid when i_ready=1
- i_ready  out  1  one-cycle completion pulse
- d_req  in  1  load/store request, level; held until d_ready
- d_rw  in  1  1=write, 0=read
- d_size  in  2  0=byte, 1=half, 2=word
- d_addr  in  32  byte address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; valid when d_ready=1
- d_ready  out  1  one-cycle completion pulse
- d_err  out  1  qualifies d_ready: out-of-window or timeout
- i_err  out  1  qualifies i_ready: out-of-window or timeout
- mem_address  out  32  to controller address
- mem_rw_req  out  1  to controller rw_req
- mem_rw  out  1  to controller rw
- mem_size  out  2  to controller size
- mem_write_data  out  32  to controller write_data
- mem_read_data  in  32  from controller read_data
- mem_data_valid  in  1  from controller data_valid, one-cycle pulse

Behaviour:
- Interface: reset is synchronous, active-low; clock is clk.
- All outputs are registered.
- On reset: all outputs are 0, state is IDLE, grant is fetch, timeout counter is 0.
- A reset asserted mid-transaction abandons the transaction; no ready pulse is issued.

State machine IDLE -> ISSUE -> WAIT -> DONE -> IDLE:
- IDLE:
  - If d_req and i_req are both high, data wins; see the optional feature.
  - The winning request's fields are latched into mem_* on the same edge.
  - Fetch requests force mem_rw=0 and mem_size=2.
  - Window check: in-window means addr>=SDRAM_BASE and addr[31]==0.
  - Out of window: go directly to DONE with err=1 and rdata=0; mem_rw_req is never raised.
  - In window: go to ISSUE.
- ISSUE:
  - Set mem_rw_req=1.
  - Clear the counter.
  - Go to WAIT next cycle.
- WAIT:
  - mem_rw_req stays 1; the counter increments each cycle.
  - If mem_data_valid=1: on that same edge, clear mem_rw_req, capture mem_read_data into the granted port's rdata, set err=0, go to DONE. This prevents the controller re-sampling a stale request when it returns to its IDLE.
  - Else if counter==TIMEOUT-1: clear mem_rw_req, set err=1, set rdata=32'hDEAD_BEEF, go to DONE.
- DONE:
  - Pulse the granted port's ready=1 for exactly one cycle, together with its err.
  - Return to IDLE.
  - Minimum turnaround is one cycle with mem_rw_req=0 between transactions.

Other rules:
- Latency for an in-window request: ready rises at the controller's data_valid cycle +1.
- Byte/half rdata is passed through unchanged; the controller already right-aligns it.
- A master may drop req only after its ready.
- A req deasserted before grant is simply not served.
- mem_data_valid outside WAIT is ignored.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register (reset to fetch) controls simultaneous requests: the port not served last wins.
  - last_grant updates in DONE.
- Undefined:
  - Fixed priority, data over fetch.
  - last_grant register is absent.

Decomposition:
- Shared package sdram_pkg:
  - size encodings SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2
  - state enum ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_DONE
  - GRANT_I/GRANT_D constants
  - DEFAULT_SDRAM_BASE
- One natural sub-module, sdram_window_check: combinational in-window decode, reused by other bus masters.

Test Plan:
- Fetch i_addr=32'h0001_0040:
  - mem_rw_req=1, mem_size=2, mem_rw=0.
  - Model asserts data_valid 12 cycles later with 32'h1234_5678.
  - i_ready pulses the next cycle, i_rdata=32'h1234_5678, i_err=0.
  - mem_rw_req low on the cycle after data_valid.
- Simultaneous i_req and d_req (d byte write to 32'h0002_0003, 8'hA5), macro undefined:
  - Data is served first with mem_size=0 and mem_write_data=32'hA5.
  - Fetch is served after the DONE gap.
- Same stimulus with ARB_ROUND_ROBIN_EN, two consecutive collisions: grants alternate d, i.
- d read at 32'h0000_8000 and at 32'h8001_0000:
  - d_ready 2 cycles after req, d_err=1, d_rdata=0.
  - mem_rw_req never asserts.
- Model never returns data_valid, TIMEOUT=16:
  - mem_rw_req drops after 16 WAIT cycles.
  - d_ready=1, d_err=1, d_rdata=32'hDEAD_BEEF.
- Reset low during WAIT:
  - Next cycle all outputs are 0 and mem_rw_req=0; no ready pulse.
  - A later data_valid is ignored.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM front end: transfer sizes, arbiter states,
// grant encodings and the default SDRAM window base.
package sdram_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [31:0] DEFAULT_SDRAM_BASE = 32'h0001_0000;

  // Read data returned to a master whose request timed out.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sdram_window_check.sv
// Combinational SDRAM window decode: an address is in the window when it is
// at or above SDRAM_BASE and bit 31 is clear. Shared by all bus masters.
module sdram_window_check
  import sdram_pkg::*;
#(
  parameter logic [31:0] SDRAM_BASE = DEFAULT_SDRAM_BASE
) (
  input  logic [31:0] addr,
  output logic        in_window
);

  assign in_window = !addr[31] && (addr >= SDRAM_BASE);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbiter between the instruction-fetch port and the load/store port in front
// of the SDRAM controller. One request at a time is registered onto mem_*,
// held until mem_data_valid (or a timeout), then completed with a one-cycle
// ready pulse to the granted port. Out-of-window requests complete locally
// with an error. Define ARB_ROUND_ROBIN_EN to resolve simultaneous requests
// in favour of the port not served last; otherwise data always wins.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter logic [31:0] SDRAM_BASE = DEFAULT_SDRAM_BASE,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic        i_err,
  output logic [31:0] mem_address,
  output logic        mem_rw_req,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_data_valid
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem_address_q, mem_address_d;
  logic             mem_rw_req_q, mem_rw_req_d;
  logic             mem_rw_q, mem_rw_d;
  logic [1:0]       mem_size_q, mem_size_d;
  logic [31:0]      mem_write_data_q, mem_write_data_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             i_ready_q, i_ready_d;
  logic             d_ready_q, d_ready_d;
  logic             i_err_q, i_err_d;
  logic             d_err_q, d_err_d;

  logic             pick_d;
  logic [31:0]      sel_addr;
  logic             sel_in_window;
  logic             finish;
  logic             done_err;
  logic [31:0]      done_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // On a collision the port that was not served last takes the grant.
  always_comb begin
    pick_d = d_req && (!i_req || (last_grant_q == GRANT_I));
  end

  // Remember which port completed, updated as the DONE state retires.
  always_comb begin
    last_grant_d = (state_q == ARB_DONE) ? grant_q : last_grant_q;
  end

  // last_grant register, starting out as if fetch was served last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= GRANT_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: a pending data request always beats fetch.
  always_comb begin
    pick_d = d_req;
  end
`endif

  assign sel_addr = pick_d ? d_addr : i_addr;

  sdram_window_check #(
    .SDRAM_BASE (SDRAM_BASE)
  ) u_window_check (
    .addr      (sel_addr),
    .in_window (sel_in_window)
  );

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT/DONE sequence.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    cnt_d            = cnt_q;
    mem_address_d    = mem_address_q;
    mem_rw_req_d     = mem_rw_req_q;
    mem_rw_d         = mem_rw_q;
    mem_size_d       = mem_size_q;
    mem_write_data_d = mem_write_data_q;
    i_rdata_d        = i_rdata_q;
    d_rdata_d        = d_rdata_q;
    i_ready_d        = 1'b0;
    d_ready_d        = 1'b0;
    i_err_d          = 1'b0;
    d_err_d          = 1'b0;
    finish           = 1'b0;
    done_err         = 1'b0;
    done_data        = '0;

    case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          grant_d = pick_d ? GRANT_D : GRANT_I;
          if (pick_d) begin
            mem_address_d    = d_addr;
            mem_rw_d         = d_rw;
            mem_size_d       = d_size;
            mem_write_data_d = d_wdata;
          end else begin
            mem_address_d    = i_addr;
            mem_rw_d         = 1'b0;
            mem_size_d       = SIZE_WORD;
            mem_write_data_d = '0;
          end
          if (sel_in_window) begin
            state_d = ARB_ISSUE;
          end else begin
            // Never reaches the controller; completes locally with an error.
            finish    = 1'b1;
            done_err  = 1'b1;
            done_data = '0;
          end
        end
      end
      ARB_ISSUE: begin
        mem_rw_req_d = 1'b1;
        cnt_d        = '0;
        state_d      = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (mem_data_valid) begin
          // Drop rw_req on the valid edge so the controller never re-samples it.
          mem_rw_req_d = 1'b0;
          finish       = 1'b1;
          done_data    = mem_read_data;
        end else if (cnt_q == CNT_LAST) begin
          mem_rw_req_d = 1'b0;
          finish       = 1'b1;
          done_err     = 1'b1;
          done_data    = TIMEOUT_RDATA;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // Entering DONE: the granted port sees ready/err during the DONE cycle.
    if (finish) begin
      state_d = ARB_DONE;
      if (grant_d == GRANT_D) begin
        d_ready_d = 1'b1;
        d_err_d   = done_err;
        d_rdata_d = done_data;
      end else begin
        i_ready_d = 1'b1;
        i_err_d   = done_err;
        i_rdata_d = done_data;
      end
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ARB_IDLE;
      grant_q          <= GRANT_I;
      cnt_q            <= '0;
      mem_address_q    <= '0;
      mem_rw_req_q     <= 1'b0;
      mem_rw_q         <= 1'b0;
      mem_size_q       <= '0;
      mem_write_data_q <= '0;
      i_rdata_q        <= '0;
      d_rdata_q        <= '0;
      i_ready_q        <= 1'b0;
      d_ready_q        <= 1'b0;
      i_err_q          <= 1'b0;
      d_err_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      cnt_q            <= cnt_d;
      mem_address_q    <= mem_address_d;
      mem_rw_req_q     <= mem_rw_req_d;
      mem_rw_q         <= mem_rw_d;
      mem_size_q       <= mem_size_d;
      mem_write_data_q <= mem_write_data_d;
      i_rdata_q        <= i_rdata_d;
      d_rdata_q        <= d_rdata_d;
      i_ready_q        <= i_ready_d;
      d_ready_q        <= d_ready_d;
      i_err_q          <= i_err_d;
      d_err_q          <= d_err_d;
    end
  end

  assign i_rdata        = i_rdata_q;
  assign i_ready        = i_ready_q;
  assign i_err          = i_err_q;
  assign d_rdata        = d_rdata_q;
  assign d_ready        = d_ready_q;
  assign d_err          = d_err_q;
  assign mem_address    = mem_address_q;
  assign mem_rw_req     = mem_rw_req_q;
  assign mem_rw         = mem_rw_q;
  assign mem_size       = mem_size_q;
  assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter. Stimulus pushes expected controller
// requests and expected port responses; a controller model and a response
// monitor pop and compare. Expectations follow ARB_ROUND_ROBIN_EN if defined.
module tb_sdram_port_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_err;
  logic        i_err;
  logic [31:0] mem_address;
  logic        mem_rw_req;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_data_valid;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .SDRAM_BASE (32'h0001_0000),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_rdata        (i_rdata),
    .i_ready        (i_ready),
    .d_req          (d_req),
    .d_rw           (d_rw),
    .d_size         (d_size),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_ready        (d_ready),
    .d_err          (d_err),
    .i_err          (i_err),
    .mem_address    (mem_address),
    .mem_rw_req     (mem_rw_req),
    .mem_rw         (mem_rw),
    .mem_size       (mem_size),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_data_valid (mem_data_valid)
  );

  typedef struct {
    logic        port;   // 0 = fetch, 1 = data
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] ret;
  } issue_t;

  resp_t  sb_q[$];
  issue_t iss_q[$];

  int checks   = 0;
  int failures = 0;
  int mem_delay     = 12;
  bit mem_never     = 1'b0;
  bit valid_honored = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_issue(input logic [31:0] a, input logic rw, input logic [1:0] sz,
                           input logic [31:0] wd, input logic [31:0] ret);
    issue_t e;
    e.addr = a; e.rw = rw; e.size = sz; e.wdata = wd; e.ret = ret;
    iss_q.push_back(e);
  endtask

  task automatic exp_resp(input logic port, input logic err, input logic [31:0] rd);
    resp_t e;
    e.port = port; e.err = err; e.rdata = rd;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic port, input logic err, input logic [31:0] rd);
    resp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_ready port=%0d actual=ready required=no_ready", port);
    end else begin
      e = sb_q.pop_front();
      chk("resp_port", {31'd0, port}, {31'd0, e.port});
      chk("resp_err", {31'd0, err}, {31'd0, e.err});
      chk("resp_rdata", rd, e.rdata);
      $display("txn port=%s err=%0d rdata=%h", port ? "d" : "i", err, rd);
    end
  endtask

  // Response monitor: every ready pulse is matched against the scoreboard.
  initial begin
    bit pi, pd;
    pi = 1'b0;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (i_ready) begin
        chk("i_ready_one_cycle", {31'd0, pi}, 32'd0);
        sb_check(1'b0, i_err, i_rdata);
      end
      if (d_ready) begin
        chk("d_ready_one_cycle", {31'd0, pd}, 32'd0);
        sb_check(1'b1, d_err, d_rdata);
      end
      pi = i_ready;
      pd = d_ready;
    end
  end

  // SDRAM controller model: checks each new request, answers after mem_delay.
  initial begin
    bit     prev;
    int     n;
    issue_t e;
    prev           = 1'b0;
    mem_data_valid = 1'b0;
    mem_read_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_rw_req && !prev) begin
        if (iss_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue addr=%h actual=rw_req required=idle", mem_address);
        end else begin
          e = iss_q.pop_front();
          chk("issue_addr", mem_address, e.addr);
          chk("issue_rw_size", {29'd0, mem_rw, mem_size}, {29'd0, e.rw, e.size});
          if (e.rw) chk("issue_wdata", mem_write_data, e.wdata);
          if (!mem_never) begin
            repeat (mem_delay) @(posedge clk);
            #1;
            mem_data_valid = 1'b1;
            mem_read_data  = e.ret;
            @(posedge clk);
            #1;
            mem_data_valid = 1'b0;
            mem_read_data  = '0;
            @(negedge clk);
            chk("ready_after_valid", {31'd0, (i_ready | d_ready)}, {31'd0, valid_honored});
            chk("rw_req_low_after_valid", {31'd0, mem_rw_req}, 32'd0);
          end else begin
            n = 1;
            while (mem_rw_req && n < 100) begin
              @(negedge clk);
              if (mem_rw_req) n++;
            end
            chk("timeout_wait_cycles", n, TO);
          end
        end
      end
      prev = mem_rw_req;
    end
  end

  // Drive the selected requests; each is dropped the edge after its ready.
  task automatic run(input bit ui, input bit ud, input int budget);
    bit pi, pd;
    int n;
    pi = ui; pd = ud; n = 0;
    i_req = ui;
    d_req = ud;
    while ((pi || pd) && n < budget) begin
      @(negedge clk);
      if (pi && i_ready) pi = 1'b0;
      if (pd && d_ready) pd = 1'b0;
      @(posedge clk);
      #1;
      if (!pi) i_req = 1'b0;
      if (!pd) d_req = 1'b0;
      n++;
    end
    checks++;
    if (pi || pd) begin
      failures++;
      $display("FAIL ready_within_budget actual=pending(i=%0d,d=%0d) required=served_in_%0d", pi, pd, budget);
      i_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_rw_req"}, {31'd0, mem_rw_req}, 32'd0);
    chk({tag, "_mem_address"}, mem_address, 32'd0);
    chk({tag, "_mem_rw_size"}, {29'd0, mem_rw, mem_size}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    chk({tag, "_rdata"}, i_rdata | d_rdata, 32'd0);
    chk({tag, "_ready_err"}, {28'd0, i_ready, d_ready, i_err, d_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_rw = 1'b0; d_size = 2'd0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fetch in window, controller answers 12 cycles after rw_req.
    i_addr = 32'h0001_0040;
    exp_issue(32'h0001_0040, 1'b0, 2'd2, 32'd0, 32'h1234_5678);
    exp_resp(1'b0, 1'b0, 32'h1234_5678);
    run(1'b1, 1'b0, 40);

    // Collision 1: data byte write versus fetch; data wins either way.
    d_addr = 32'h0002_0003; d_rw = 1'b1; d_size = 2'd0; d_wdata = 32'h0000_00A5;
    i_addr = 32'h0001_0080;
    exp_issue(32'h0002_0003, 1'b1, 2'd0, 32'h0000_00A5, 32'h0000_0011);
    exp_resp(1'b1, 1'b0, 32'h0000_0011);
    exp_issue(32'h0001_0080, 1'b0, 2'd2, 32'd0, 32'h2222_0000);
    exp_resp(1'b0, 1'b0, 32'h2222_0000);
    run(1'b1, 1'b1, 80);

    // Data word read alone at the window base, so data becomes last served.
    d_addr = 32'h0001_0000; d_rw = 1'b0; d_size = 2'd2; d_wdata = 32'h0;
    exp_issue(32'h0001_0000, 1'b0, 2'd2, 32'd0, 32'h3333_4444);
    exp_resp(1'b1, 1'b0, 32'h3333_4444);
    run(1'b0, 1'b1, 40);

    // Collision 2: round robin now favours fetch, fixed priority still data.
    d_addr = 32'h0003_0002; d_rw = 1'b0; d_size = 2'd1;
    i_addr = 32'h0001_00C0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_issue(32'h0001_00C0, 1'b0, 2'd2, 32'd0, 32'h5555_6666);
    exp_resp(1'b0, 1'b0, 32'h5555_6666);
    exp_issue(32'h0003_0002, 1'b0, 2'd1, 32'd0, 32'h0000_BEEF);
    exp_resp(1'b1, 1'b0, 32'h0000_BEEF);
`else
    exp_issue(32'h0003_0002, 1'b0, 2'd1, 32'd0, 32'h0000_BEEF);
    exp_resp(1'b1, 1'b0, 32'h0000_BEEF);
    exp_issue(32'h0001_00C0, 1'b0, 2'd2, 32'd0, 32'h5555_6666);
    exp_resp(1'b0, 1'b0, 32'h5555_6666);
`endif
    run(1'b1, 1'b1, 80);

    // Out-of-window requests complete locally within two cycles.
    d_addr = 32'h0000_8000; d_size = 2'd2;
    exp_resp(1'b1, 1'b1, 32'd0);
    run(1'b0, 1'b1, 2);
    d_addr = 32'h8001_0000;
    exp_resp(1'b1, 1'b1, 32'd0);
    run(1'b0, 1'b1, 2);
    i_addr = 32'h0000_FFFC;
    exp_resp(1'b0, 1'b1, 32'd0);
    run(1'b1, 1'b0, 2);

    // Controller never answers: timeout after TO wait cycles.
    mem_never = 1'b1;
    d_addr = 32'h0001_0300; d_rw = 1'b0; d_size = 2'd2;
    exp_issue(32'h0001_0300, 1'b0, 2'd2, 32'd0, 32'd0);
    exp_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
    run(1'b0, 1'b1, 60);
    repeat (2) @(posedge clk);
    #1;
    mem_never = 1'b0;

    // Reset during WAIT: transaction abandoned, late data_valid ignored.
    valid_honored = 1'b0;
    d_addr = 32'h0001_0100;
    exp_issue(32'h0001_0100, 1'b0, 2'd2, 32'd0, 32'hCAFE_0001);
    d_req = 1'b1;
    n = 0;
    while (!mem_rw_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reset_test_in_wait", {31'd0, mem_rw_req}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_outputs_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    valid_honored = 1'b1;

    // Normal service resumes after the abandoned transaction.
    i_addr = 32'h0001_0400;
    exp_issue(32'h0001_0400, 1'b0, 2'd2, 32'd0, 32'h7777_8888);
    exp_resp(1'b0, 1'b0, 32'h7777_8888);
    run(1'b1, 1'b0, 40);

    repeat (4) @(posedge clk);
    #1;
    chk("resp_queue_drained", sb_q.size(), 32'd0);
    chk("issue_queue_drained", iss_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
